add_4bit_core: RTL and testbench

Registered 4-bit unsigned adder built as a ripple-carry chain of four full-adder cells. It is the basic add primitive for the CPU datapath and serves as the building block for wider adders and the ALU add path. Operands are sampled every clock. The 5-bit sum and the carry-out appear one cycle later.

---
 rtl/add_4bit_core.sv | 44 ++++
 tb/tb_add_4bit_core.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/add_4bit_core.sv
// Registered 4-bit unsigned ripple-carry adder with a 1-cycle result latency.
// Optional carry-in port is enabled by defining ADD4_CIN_EN.
module add_4bit_core (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
`ifdef ADD4_CIN_EN
    input  logic       c_in,
`endif
    output logic [4:0] out,
    output logic       c_out
);

    logic [4:0] c;
    logic [3:0] s;

`ifdef ADD4_CIN_EN
    assign c[0] = c_in;
`else
    assign c[0] = 1'b0;
`endif

    // Four full-adder cells chained LSB to MSB; c[4] is the final carry.
    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_fa
            assign s[i]   = a[i] ^ b[i] ^ c[i];
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    // Both registers load from c[4], so c_out always tracks out[4].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= 5'b00000;
            c_out <= 1'b0;
        end else begin
            out   <= {c[4], s};
            c_out <= c[4];
        end
    end

endmodule

// File: tb/tb_add_4bit_core.sv
// Self-checking bench for add_4bit_core: directed vector table, reset and
// pipelining sequences, and an exhaustive operand sweep.
module tb_add_4bit_core;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [4:0] exp_out;
        string      name;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       c_in;
    logic [4:0] out;
    logic       c_out;

    int checks;
    int errors;

    add_4bit_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
`ifdef ADD4_CIN_EN
        .c_in  (c_in),
`endif
        .out   (out),
        .c_out (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] exp_out, input logic exp_cout);
        checks++;
        if (out !== exp_out || c_out !== exp_cout) begin
            errors++;
            $display("FAIL %s: out=%0d c_out=%0b, required out=%0d c_out=%0b",
                     name, out, c_out, exp_out, exp_cout);
        end
    endtask

    // Drive operands at the current negedge, then check after the next rising edge.
    task automatic drive(input logic [3:0] va, input logic [3:0] vb, input logic vcin);
        a    = va;
        b    = vb;
        c_in = vcin;
    endtask

    initial begin
        vec_t vecs[$];
        checks = 0;
        errors = 0;

        vecs.push_back('{4'd0,  4'd0,  1'b0, 5'd0,  "zero"});
        vecs.push_back('{4'd3,  4'd1,  1'b0, 5'd4,  "basic_3_1"});
        vecs.push_back('{4'd15, 4'd1,  1'b0, 5'd16, "carry_15_1"});
        vecs.push_back('{4'd15, 4'd15, 1'b0, 5'd30, "carry_15_15"});
        vecs.push_back('{4'd8,  4'd7,  1'b0, 5'd15, "no_carry_8_7"});
        vecs.push_back('{4'd10, 4'd5,  1'b0, 5'd15, "alt_bits"});
        vecs.push_back('{4'd9,  4'd12, 1'b0, 5'd21, "mixed_9_12"});
`ifdef ADD4_CIN_EN
        vecs.push_back('{4'd15, 4'd15, 1'b1, 5'd31, "cin_max"});
        vecs.push_back('{4'd3,  4'd1,  1'b1, 5'd5,  "cin_3_1"});
        vecs.push_back('{4'd0,  4'd0,  1'b1, 5'd1,  "cin_only"});
        vecs.push_back('{4'd7,  4'd8,  1'b1, 5'd16, "cin_ripple"});
`endif

        // Reset held: outputs stay zero while the clock toggles.
        rst_n = 1'b0;
        drive(4'd9, 4'd9, 1'b0);
        #1;
        check("reset_async", 5'd0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("reset_hold", 5'd0, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_release", 5'd18, 1'b1);

        // Basic add with hold while inputs are stable.
        drive(4'd0, 4'd0, 1'b0);
        @(negedge clk);
        check("basic_zero", 5'd0, 1'b0);
        drive(4'b0011, 4'b0001, 1'b0);
        @(negedge clk);
        check("basic_add", 5'd4, 1'b0);
        @(negedge clk);
        check("basic_hold", 5'd4, 1'b0);

        // Operand change between edges must not disturb the registered output.
        drive(4'd15, 4'd15, 1'b0);
        #2;
        check("mid_cycle_change", 5'd4, 1'b0);
        @(negedge clk);
        check("mid_cycle_capture", 5'd30, 1'b1);

        // Table-driven directed vectors.
        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].cin);
            @(negedge clk);
            check(vecs[i].name, vecs[i].exp_out, vecs[i].exp_out[4]);
        end

        // Back-to-back operands on consecutive edges.
        drive(4'd1, 4'd2, 1'b0);
        @(negedge clk);
        check("pipe_1", 5'd3, 1'b0);
        drive(4'd5, 4'd5, 1'b0);
        @(negedge clk);
        check("pipe_2", 5'd10, 1'b0);
        drive(4'd15, 4'd0, 1'b0);
        @(negedge clk);
        check("pipe_3", 5'd15, 1'b0);

        // Async reset mid-stream discards the in-flight operands.
        drive(4'd15, 4'd15, 1'b0);
        @(negedge clk);
        check("pre_reset", 5'd30, 1'b1);
        drive(4'd7, 4'd7, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midstream_reset_now", 5'd0, 1'b0);
        @(negedge clk);
        check("midstream_reset_hold", 5'd0, 1'b0);
        drive(4'd2, 4'd3, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_new_ops", 5'd5, 1'b0);

        // Exhaustive sweep against the arithmetic sum.
`ifdef ADD4_CIN_EN
        for (int ci = 0; ci < 2; ci++) begin
`else
        for (int ci = 0; ci < 1; ci++) begin
`endif
            for (int ia = 0; ia < 16; ia++) begin
                for (int ib = 0; ib < 16; ib++) begin
                    logic [4:0] exp_sum;
                    exp_sum = 5'(ia + ib + ci);
                    drive(4'(ia), 4'(ib), 1'(ci));
                    @(negedge clk);
                    check("sweep", exp_sum, exp_sum[4]);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
